// File: rtl/fsgnj_operand_stage_if.sv
// fsgnj_operand_stage_if: operand/handshake bus between the FP register-file read and the sign-injection prep stage
interface fsgnj_operand_stage_if #(
  parameter int FLEN = 64,
  parameter int TAGW = 5
);
  logic            Flush, InValid, InReady, FmtIn, OutValid, OutReady, Xs, Ys, Fmt;
  logic [FLEN-1:0] XIn, YIn, X;
  logic [1:0]      OpCtrlIn, OpCtrl, BoxErr;
  logic [TAGW-1:0] TagIn, Tag;
  modport master (
    output Flush, InValid, XIn, YIn, FmtIn, OpCtrlIn, TagIn, OutReady,
    input  InReady, OutValid, X, Xs, Ys, Fmt, OpCtrl, Tag, BoxErr
  );
  modport slave (
    input  Flush, InValid, XIn, YIn, FmtIn, OpCtrlIn, TagIn, OutReady,
    output InReady, OutValid, X, Xs, Ys, Fmt, OpCtrl, Tag, BoxErr
  );
endinterface

// File: rtl/fsgnj_operand_stage.sv
// fsgnj_operand_stage: NaN-box check and sign extraction ahead of sign injection, behind a 2-entry skid buffer
module fsgnj_operand_stage #(
  parameter int FLEN = 64,
  parameter int LEN1 = 32,
  parameter int TAGW = 5
) (
  input logic clk,
  input logic reset,
  fsgnj_operand_stage_if.slave bus
);
  typedef struct packed {
    logic [FLEN-1:0] x;
    logic            xs;
    logic            ys;
    logic            fmt;
    logic [1:0]      op;
    logic [TAGW-1:0] tag;
    logic [1:0]      box_err;
  } entry_t;
  localparam logic [FLEN-1:0] CANON_NAN = {{(FLEN-LEN1){1'b1}}, LEN1'(32'h7FC0_0000)};
  entry_t in_e, out_q, out_d, skid_q, skid_d;
  logic   out_v_q, out_v_d, skid_v_q, skid_v_d, x_bad, y_bad, acc, pop;
  always_comb begin
    x_bad       = !bus.FmtIn && !(&bus.XIn[FLEN-1:LEN1]);
    y_bad       = !bus.FmtIn && !(&bus.YIn[FLEN-1:LEN1]);
    in_e.x      = x_bad ? CANON_NAN : bus.XIn;
    in_e.xs     = bus.FmtIn ? bus.XIn[FLEN-1] : !x_bad && bus.XIn[LEN1-1];
    in_e.ys     = bus.FmtIn ? bus.YIn[FLEN-1] : !y_bad && bus.YIn[LEN1-1];
    in_e.fmt    = bus.FmtIn;
    in_e.op     = bus.OpCtrlIn;
    in_e.tag    = bus.TagIn;
    in_e.box_err = {y_bad, x_bad};
    acc         = bus.InValid && !skid_v_q;
    pop         = out_v_q && bus.OutReady;
    // the output register refills from skid first so order stays FIFO
    out_v_d     = skid_v_q || acc || (out_v_q && !pop);
    out_d       = (!out_v_q || pop) ? (skid_v_q ? skid_q : (acc ? in_e : out_q)) : out_q;
    skid_v_d    = skid_v_q ? !pop : (acc && out_v_q && !pop);
    skid_d      = (!skid_v_q && acc && out_v_q && !pop) ? in_e : skid_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
    end else if (bus.Flush) begin
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      out_v_q  <= out_v_d;
      skid_v_q <= skid_v_d;
      out_q    <= out_d;
      skid_q   <= skid_d;
    end
  end
  assign bus.InReady  = !skid_v_q;
  assign bus.OutValid = out_v_q;
  assign bus.X        = out_q.x;
  assign bus.Xs       = out_q.xs;
  assign bus.Ys       = out_q.ys;
  assign bus.Fmt      = out_q.fmt;
  assign bus.OpCtrl   = out_q.op;
  assign bus.Tag      = out_q.tag;
  assign bus.BoxErr   = out_q.box_err;
endmodule

// File: tb/tb_fsgnj_operand_stage.sv
// tb_fsgnj_operand_stage: scenario tasks with a reference-model scoreboard for fsgnj_operand_stage
module tb_fsgnj_operand_stage;
  typedef struct packed {
    logic [63:0] x;
    logic        xs;
    logic        ys;
    logic        fmt;
    logic [1:0]  op;
    logic [4:0]  tag;
    logic [1:0]  be;
  } ent_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cmp = 0;
  int   err = 0;
  ent_t sbq[$];
  fsgnj_operand_stage_if #(.FLEN(64), .TAGW(5)) bus ();
  fsgnj_operand_stage #(.FLEN(64), .LEN1(32), .TAGW(5)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic ent_t model(input logic [63:0] x, input logic [63:0] y, input logic f,
                                 input logic [1:0] op, input logic [4:0] tag);
    ent_t m;
    logic xb, yb;
    xb    = (x[63:32] == 32'hFFFF_FFFF);
    yb    = (y[63:32] == 32'hFFFF_FFFF);
    m.x   = (!f && !xb) ? 64'hFFFF_FFFF_7FC0_0000 : x;
    m.xs  = f ? x[63] : (xb ? x[31] : 1'b0);
    m.ys  = f ? y[63] : (yb ? y[31] : 1'b0);
    m.fmt = f;
    m.op  = op;
    m.tag = tag;
    m.be  = {!f && !yb, !f && !xb};
    return m;
  endfunction
  function automatic ent_t cur_out();
    return {bus.X, bus.Xs, bus.Ys, bus.Fmt, bus.OpCtrl, bus.Tag, bus.BoxErr};
  endfunction
  task automatic drive(input logic v, input logic [63:0] x, input logic [63:0] y, input logic f,
                       input logic [1:0] op, input logic [4:0] tag);
    bus.InValid  = v;
    bus.XIn      = x;
    bus.YIn      = y;
    bus.FmtIn    = f;
    bus.OpCtrlIn = op;
    bus.TagIn    = tag;
  endtask
  // advances one clock; reports what was popped and records accepted stimulus in the scoreboard
  task automatic step(output logic popped, output ent_t got);
    popped = bus.OutValid && bus.OutReady && !bus.Flush && !reset;
    got    = cur_out();
    if (reset || bus.Flush) sbq.delete();
    else if (bus.InValid && bus.InReady)
      sbq.push_back(model(bus.XIn, bus.YIn, bus.FmtIn, bus.OpCtrlIn, bus.TagIn));
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    logic p;
    ent_t g;
    reset = 1'b1;
    bus.Flush = 1'b0;
    bus.OutReady = 1'b0;
    drive(1'b0, 64'd0, 64'd0, 1'b0, 2'd0, 5'd0);
    step(p, g);
    step(p, g);
    reset = 1'b0;
    cmp++;
    if ({bus.OutValid, bus.InReady} !== 2'b01) begin
      err++;
      $display("FAIL reset_hs: OutValid/InReady=%b expected 01", {bus.OutValid, bus.InReady});
    end
    cmp++;
    if (cur_out() !== '0) begin
      err++;
      $display("FAIL reset_data: got %h expected 0", cur_out());
    end
  endtask
  task automatic test_format(input string name, input logic [63:0] x, input logic [63:0] y, input logic f,
                             input logic [4:0] tag, input logic [63:0] ex, input logic exs, input logic eys,
                             input logic [1:0] ebe);
    logic p;
    ent_t g, e;
    bus.OutReady = 1'b1;
    drive(1'b1, x, y, f, 2'b00, tag);
    step(p, g);
    drive(1'b0, 64'd0, 64'd0, 1'b0, 2'd0, 5'd0);
    cmp++;
    if ({bus.OutValid, bus.X, bus.Xs, bus.Ys, bus.BoxErr} !== {1'b1, ex, exs, eys, ebe}) begin
      err++;
      $display("FAIL %s: v=%b X=%h Xs=%b Ys=%b BoxErr=%b expected v=1 X=%h Xs=%b Ys=%b BoxErr=%b",
               name, bus.OutValid, bus.X, bus.Xs, bus.Ys, bus.BoxErr, ex, exs, eys, ebe);
    end
    step(p, g);
    cmp++;
    if (!p || sbq.size() == 0) begin
      err++;
      $display("FAIL %s_pop: popped=%b queued=%0d expected one pop", name, p, sbq.size());
    end else begin
      e = sbq.pop_front();
      if (g !== e) begin
        err++;
        $display("FAIL %s_sb: got %h expected %h", name, g, e);
      end
    end
  endtask
  task automatic test_backpressure();
    logic p;
    ent_t g, e;
    bus.OutReady = 1'b0;
    drive(1'b1, 64'h3FF0_0000_0000_0000, 64'h0, 1'b1, 2'b01, 5'd1);
    step(p, g);
    drive(1'b1, 64'hFFFF_FFFF_C000_0000, 64'h0, 1'b0, 2'b10, 5'd2);
    step(p, g);
    drive(1'b0, 64'd0, 64'd0, 1'b0, 2'd0, 5'd7);
    cmp++;
    if (bus.InReady !== 1'b0) begin
      err++;
      $display("FAIL bp_full: InReady=%b expected 0", bus.InReady);
    end
    step(p, g);
    cmp++;
    if ({bus.OutValid, bus.Tag, bus.X} !== {1'b1, 5'd1, 64'h3FF0_0000_0000_0000}) begin
      err++;
      $display("FAIL bp_hold: v=%b tag=%0d X=%h expected v=1 tag=1 X=3ff0000000000000", bus.OutValid, bus.Tag, bus.X);
    end
    bus.OutReady = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      step(p, g);
      cmp++;
      if (!p || g.tag !== 5'(i) || sbq.size() == 0) begin
        err++;
        $display("FAIL bp_order: popped=%b tag=%0d expected tag %0d", p, g.tag, i);
      end else begin
        e = sbq.pop_front();
        if (g !== e) begin
          err++;
          $display("FAIL bp_sb: got %h expected %h", g, e);
        end
      end
      if (i == 1) begin
        cmp++;
        if (bus.InReady !== 1'b1) begin
          err++;
          $display("FAIL bp_ready: InReady=%b expected 1 after first pop", bus.InReady);
        end
      end
    end
    cmp++;
    if (bus.OutValid !== 1'b0) begin
      err++;
      $display("FAIL bp_empty: OutValid=%b expected 0", bus.OutValid);
    end
  endtask
  task automatic test_flush(input int occ);
    logic p;
    ent_t g;
    bus.OutReady = 1'b0;
    for (int i = 0; i < occ; i++) begin
      drive(1'b1, 64'h4000_0000_0000_0000, 64'h0, 1'b1, 2'b00, 5'(3 + i));
      step(p, g);
    end
    drive(1'b1, 64'h4010_0000_0000_0000, 64'h0, 1'b1, 2'b00, 5'd5);
    bus.Flush = 1'b1;
    step(p, g);
    bus.Flush = 1'b0;
    drive(1'b0, 64'd0, 64'd0, 1'b0, 2'd0, 5'd0);
    cmp++;
    if ({bus.OutValid, bus.InReady} !== 2'b01) begin
      err++;
      $display("FAIL flush_occ%0d: OutValid/InReady=%b expected 01", occ, {bus.OutValid, bus.InReady});
    end
    bus.OutReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(p, g);
      cmp++;
      if (p) begin
        err++;
        $display("FAIL flush_leak%0d: got tag %0d expected no output", occ, g.tag);
      end
    end
  endtask
  task automatic test_back_to_back();
    logic p;
    ent_t g, e;
    int pops = 0;
    bus.OutReady = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      drive(i < 10, {32'hFFFF_FFFF, 32'(i) << 20}, {32'(i), 32'h8000_0000}, 1'b0, 2'(i), 5'(i));
      cmp++;
      if (bus.InReady !== 1'b1) begin
        err++;
        $display("FAIL b2b_ready: cycle %0d InReady=%b expected 1", i, bus.InReady);
      end
      step(p, g);
      if (p) begin
        pops++;
        cmp++;
        if (sbq.size() == 0) begin
          err++;
          $display("FAIL b2b_sb: got tag %0d expected none", g.tag);
        end else begin
          e = sbq.pop_front();
          if (g !== e) begin
            err++;
            $display("FAIL b2b_sb: got %h expected %h", g, e);
          end
        end
      end
    end
    cmp++;
    if (pops != 10) begin
      err++;
      $display("FAIL b2b_count: got %0d pops expected 10", pops);
    end
  endtask
  task automatic test_random();
    logic p;
    ent_t g, e;
    logic [63:0] x, y;
    for (int i = 0; i < 300; i++) begin
      x = {($urandom_range(0, 2) == 0) ? 32'($urandom) : 32'hFFFF_FFFF, 32'($urandom)};
      y = {($urandom_range(0, 2) == 0) ? 32'($urandom) : 32'hFFFF_FFFF, 32'($urandom)};
      drive(i < 290 && $urandom_range(0, 3) != 0, x, y, 1'($urandom), 2'($urandom), 5'($urandom));
      bus.OutReady = (i >= 290) || ($urandom_range(0, 2) != 0);
      step(p, g);
      if (p) begin
        cmp++;
        if (sbq.size() == 0) begin
          err++;
          $display("FAIL rnd_sb: got tag %0d expected none", g.tag);
        end else begin
          e = sbq.pop_front();
          if (g !== e) begin
            err++;
            $display("FAIL rnd_sb: got %h expected %h", g, e);
          end
        end
      end
    end
    cmp++;
    if (sbq.size() != 0 || bus.OutValid !== 1'b0) begin
      err++;
      $display("FAIL rnd_drain: %0d entries outstanding, OutValid=%b expected 0/0", sbq.size(), bus.OutValid);
    end
  endtask
  task automatic test_reset_mid();
    logic p;
    ent_t g;
    bus.OutReady = 1'b0;
    drive(1'b1, 64'hC000_0000_0000_0000, 64'hC000_0000_0000_0000, 1'b1, 2'b11, 5'd9);
    step(p, g);
    cmp++;
    if ({bus.OutValid, bus.OpCtrl, bus.Tag} !== {1'b1, 2'b11, 5'd9}) begin
      err++;
      $display("FAIL rst_pre: v=%b op=%b tag=%0d expected v=1 op=11 tag=9", bus.OutValid, bus.OpCtrl, bus.Tag);
    end
    drive(1'b0, 64'd0, 64'd0, 1'b0, 2'd0, 5'd0);
    reset = 1'b1;
    bus.Flush = 1'b1;
    step(p, g);
    reset = 1'b0;
    bus.Flush = 1'b0;
    cmp++;
    if ({bus.OutValid, bus.InReady, cur_out()} !== {2'b01, 76'd0}) begin
      err++;
      $display("FAIL rst_mid: v=%b rdy=%b out=%h expected v=0 rdy=1 out=0", bus.OutValid, bus.InReady, cur_out());
    end
  endtask
  initial begin
    test_reset();
    test_format("dbl", 64'h4000_0000_0000_0000, 64'hC000_0000_0000_0000, 1'b1, 5'd1,
                64'h4000_0000_0000_0000, 1'b0, 1'b1, 2'b00);
    test_format("sgl_boxed", 64'hFFFF_FFFF_3F80_0000, 64'hFFFF_FFFF_BF80_0000, 1'b0, 5'd2,
                64'hFFFF_FFFF_3F80_0000, 1'b0, 1'b1, 2'b00);
    test_format("sgl_unboxed", 64'h0000_0000_3F80_0000, 64'h1234_5678_BF80_0000, 1'b0, 5'd3,
                64'hFFFF_FFFF_7FC0_0000, 1'b0, 1'b0, 2'b11);
    test_format("sgl_xonly", 64'hFFFF_FFFE_BF80_0000, 64'hFFFF_FFFF_3F80_0000, 1'b0, 5'd4,
                64'hFFFF_FFFF_7FC0_0000, 1'b0, 1'b0, 2'b01);
    test_backpressure();
    test_flush(2);
    test_flush(1);
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule

// File: doc/fsgnj_operand_stage.md
Name: fsgnj_operand_stage

Overview:
- Registered operand-preparation stage directly upstream of the FPU sign-injection unit.
- Takes raw FP register-file operands and the decoded op, checks NaN-boxing of single-precision operands, and substitutes the canonical NaN for improperly boxed operands.
- Extracts the X/Y sign bits for the active format and delivers X, Xs, Ys, Fmt and OpCtrl to the sign-injection unit.
- Decoupled by a valid/ready handshake with a 2-entry skid buffer (output register + skid register), so the ready path is fully registered.

Parameters:
FLEN, 64, full operand width (double)
LEN1, 32, narrow format width (single); NaN-box region is FLEN-1:LEN1
TAGW, 5, width of opaque destination tag carried alongside the operands

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
Flush  in  1  discard all held entries and any same-cycle accept
InValid  in  1  upstream operand valid
InReady  out  1  stage can accept (registered)
XIn  in  FLEN  raw operand X
YIn  in  FLEN  raw operand Y
FmtIn  in  1  1 = double (FLEN), 0 = single (LEN1)
OpCtrlIn  in  2  00 fsgnj, 01 fsgnjn, 10 fsgnjx
TagIn  in  TAGW  destination tag
OutValid  out  1  output entry valid
OutReady  in  1  downstream accepts
X  out  FLEN  prepared X (canonical-NaN substituted if unboxed)
Xs  out  1  X sign for active format
Ys  out  1  Y sign for active format
Fmt  out  1  registered format
OpCtrl  out  2  registered op
Tag  out  TAGW  registered tag
BoxErr  out  2  {Y unboxed, X unboxed}, informational

Behaviour:
- Reset (synchronous, active-high): OutValid=0, skid entry invalid, InReady=1. X, Xs, Ys, Fmt, OpCtrl, Tag, BoxErr all zero.
- Preparation is combinational on the inputs, computed before capture:
  - Fmt=1: Xp=XIn; Xs=XIn[FLEN-1]; Ys=YIn[FLEN-1]; BoxErr=00.
  - Fmt=0, operand boxed (bits FLEN-1:LEN1 all ones): Xp=XIn; sign = bit LEN1-1.
  - Fmt=0, operand not boxed: that operand becomes the canonical NaN {ones(FLEN-LEN1), 0x7FC00000}. Its sign = 0 and its BoxErr bit = 1.
  - Y substitution only affects Ys; Y itself is not forwarded.
- Accept: InValid & InReady.
- Output: OutValid with X/Xs/Ys/Fmt/OpCtrl/Tag/BoxErr from the output register.
- Latency: 1 cycle from accept to OutValid when empty.
- Pop: OutValid & OutReady.
- Occupancy 0, 1 or 2 (output register, skid register). InReady = skid register empty (registered).
- Transitions:
  - Empty, accept → output register loaded; occupancy 1.
  - Occ 1, accept, no pop → new entry into skid; occupancy 2; InReady drops next cycle.
  - Occ 1, accept + pop → output register reloaded with new entry; occupancy stays 1.
  - Occ 1, pop only → empty.
  - Occ 2, pop → skid moves to output register; occupancy 1; InReady=1 next cycle.
  - Occ 2: InReady=0, so no accept is possible.
- Order: strict FIFO; no entry is duplicated or dropped.
- Output stability: while OutValid=1 and OutReady=0, all output fields are held stable.
- Flush: next cycle OutValid=0, skid invalid, InReady=1. A same-cycle accept is discarded. Flush takes priority over pop and accept.
- Reset asserted mid-transfer: identical to flush. Reset takes priority over Flush.
- OpCtrlIn=11 is passed through unchanged; no check is made.

Test Plan:
1. Fmt=1, XIn=0x4000000000000000, YIn=0xC000000000000000, OpCtrl=00, OutReady=1 → next cycle OutValid=1, X=0x4000000000000000, Xs=0, Ys=1, BoxErr=00.
2. Fmt=0, XIn=0xFFFFFFFF3F800000, YIn=0xFFFFFFFFBF800000 → Xs=0, Ys=1, X unchanged, BoxErr=00.
3. Fmt=0, XIn=0x000000003F800000, YIn=0x12345678BF800000 → X=0xFFFFFFFF7FC00000, Xs=0, Ys=0, BoxErr=11.
4. OutReady=0; push tags 1, 2 on back-to-back cycles → InReady=0 after the second accept. Raise OutReady → tags pop in order 1 then 2, and InReady returns to 1 the cycle after the first pop.
5. Occupancy 2 (tags 3, 4), Flush=1 with InValid=1 tag 5 → next cycle OutValid=0, InReady=1. Tag 5 never appears.
6. Continuous InValid=1, OutReady=1, tags 0..9 → one output per cycle, no bubbles, tags 0..9 in order.
7. Assert reset for 1 cycle with occupancy 1 → OutValid=0, all outputs 0, InReady=1.
